// File: rtl/hc259_writer.sv
// Bit-serial writer for an external 74HC259-style addressable latch, with a shadow copy of its contents.
// Optional HC259_WRITER_SKIP_EN: bits already matching SHADOW take a 1-cycle SKIP instead of a strobe.
module hc259_writer #(
    parameter int SETUP_CYC = 1,
    parameter int LE_CYC    = 1
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       START,
    input  logic       CLR,
    input  logic [7:0] DATA,
    output logic [2:0] A,
    output logic       D,
    output logic       nLE,
    output logic       nMR,
    output logic       BUSY,
    output logic       DONE,
    output logic [7:0] SHADOW
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CLEAR  = 3'd1;
    localparam logic [2:0] SETUP  = 3'd2;
    localparam logic [2:0] STROBE = 3'd3;
    localparam logic [2:0] HOLD   = 3'd4;
    localparam logic [2:0] FIN    = 3'd5;
`ifdef HC259_WRITER_SKIP_EN
    localparam logic [2:0] SKIP   = 3'd6;
`endif

    localparam logic [2:0] SETUP_LAST = 3'(SETUP_CYC - 1);
    localparam logic [2:0] LE_LAST    = 3'(LE_CYC - 1);

    logic [2:0] state;
    logic [2:0] stateNext;
    logic [2:0] cnt;
    logic [2:0] cntNext;
    logic [2:0] idx;
    logic [2:0] idxNext;
    logic [7:0] dataReg;
    logic [7:0] srcData;

    // In IDLE the bit about to be presented comes straight from DATA, before dataReg is loaded.
    assign srcData = (state == IDLE) ? DATA : dataReg;

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        idxNext   = idx;
        case (state)
            IDLE: begin
                if (CLR) begin
                    stateNext = CLEAR;
                end else if (START) begin
                    idxNext = '0;
                    cntNext = '0;
`ifdef HC259_WRITER_SKIP_EN
                    stateNext = (DATA[0] == SHADOW[0]) ? SKIP : SETUP;
`else
                    stateNext = SETUP;
`endif
                end
            end
            CLEAR: begin
                stateNext = FIN;
            end
            SETUP: begin
                if (cnt == SETUP_LAST) begin
                    cntNext   = '0;
                    stateNext = STROBE;
                end else begin
                    cntNext = cnt + 3'd1;
                end
            end
            STROBE: begin
                if (cnt == LE_LAST) begin
                    cntNext   = '0;
                    stateNext = HOLD;
                end else begin
                    cntNext = cnt + 3'd1;
                end
            end
`ifdef HC259_WRITER_SKIP_EN
            HOLD, SKIP: begin
`else
            HOLD: begin
`endif
                if (idx == 3'd7) begin
                    stateNext = FIN;
                end else begin
                    idxNext = idx + 3'd1;
                    cntNext = '0;
`ifdef HC259_WRITER_SKIP_EN
                    stateNext = (dataReg[idxNext] == SHADOW[idxNext]) ? SKIP : SETUP;
`else
                    stateNext = SETUP;
`endif
                end
            end
            FIN: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up exactly with the state register.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            dataReg <= '0;
            A       <= '0;
            D       <= 1'b0;
            nLE     <= 1'b1;
            nMR     <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            SHADOW  <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            idx   <= idxNext;
            if (state == IDLE && !CLR && START) begin
                dataReg <= DATA;
            end
            nLE  <= (stateNext != STROBE);
            nMR  <= (stateNext != CLEAR);
            BUSY <= !(stateNext == IDLE || stateNext == FIN);
            DONE <= (stateNext == FIN);
            // A/D only move on entry to SETUP, so they are frozen through STROBE, HOLD and SKIP.
            if (stateNext == SETUP && state != SETUP) begin
                A <= idxNext;
                D <= srcData[idxNext];
            end
            if (stateNext == CLEAR) begin
                SHADOW <= '0;
            end else if (state == STROBE && stateNext == HOLD) begin
                SHADOW[idx] <= dataReg[idx];
            end
        end
    end

endmodule

// File: tb/tb_hc259_writer.sv
// Directed bench for hc259_writer: default instance plus a SETUP_CYC=2/LE_CYC=3 instance, each with a latch model.
module tb_hc259_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       nRST;
    logic       aStart, aClr, bStart, bClr;
    logic [7:0] aData, bData;
    logic [2:0] aA, bA;
    logic       aD, aNLE, aNMR, aBusy, aDone;
    logic       bD, bNLE, bNMR, bBusy, bDone;
    logic [7:0] aShadow, bShadow;

    int checks = 0;
    int errors = 0;

`ifdef HC259_WRITER_SKIP_EN
    localparam int LAT_A5    = 17;
    localparam int PULSES_A5 = 4;
`else
    localparam int LAT_A5    = 25;
    localparam int PULSES_A5 = 8;
`endif

    hc259_writer dutA (
        .CLK(clk), .nRST(nRST), .START(aStart), .CLR(aClr), .DATA(aData),
        .A(aA), .D(aD), .nLE(aNLE), .nMR(aNMR), .BUSY(aBusy), .DONE(aDone), .SHADOW(aShadow)
    );

    hc259_writer #(.SETUP_CYC(2), .LE_CYC(3)) dutB (
        .CLK(clk), .nRST(nRST), .START(bStart), .CLR(bClr), .DATA(bData),
        .A(bA), .D(bD), .nLE(bNLE), .nMR(bNMR), .BUSY(bBusy), .DONE(bDone), .SHADOW(bShadow)
    );

    // Behavioural addressable latches plus protocol monitors, sampled mid-cycle.
    logic [7:0] latchA = 8'h00;
    logic [7:0] latchB = 8'h00;
    logic [3:0] logA [64];
    int pulsesA = 0, violA = 0, nmrLowA = 0, doneA = 0;
    int pulsesB = 0, violB = 0, lowRunB = 0;
    logic       pNA = 1'b1, pNB = 1'b1, h2N = 1'b1;
    logic [2:0] pAA = 3'd0, pAB = 3'd0, h2A = 3'd0;
    logic       pDA = 1'b0, pDB = 1'b0, h2D = 1'b0;

    always @(negedge clk) begin
        if (nRST === 1'b1) begin
            if (!aNLE && !aNMR) violA++;
            if (!aNLE && !pNA && (aA !== pAA || aD !== pDA)) violA++;
            if (!aNLE && pNA) begin
                logA[pulsesA % 64] = {aA, aD};
                pulsesA++;
            end
            if (!aNMR) nmrLowA++;
            if (aDone) doneA++;
        end
        if (!aNMR) latchA = 8'h00;
        else if (!aNLE) latchA[aA] = aD;
        pNA = aNLE; pAA = aA; pDA = aD;
    end

    always @(negedge clk) begin
        if (nRST === 1'b1) begin
            if (!bNLE && !bNMR) violB++;
            if (!bNLE && !pNB && (bA !== pAB || bD !== pDB)) violB++;
            if (!bNLE && pNB) begin
                pulsesB++;
                if (!(h2N && h2A == bA && pAB == bA && h2D == bD && pDB == bD)) violB++;
            end
            if (!bNLE) lowRunB++;
            if (bNLE && !pNB) begin
                if (lowRunB != 3) violB++;
                lowRunB = 0;
            end
        end
        if (!bNMR) latchB = 8'h00;
        else if (!bNLE) latchB[bA] = bD;
        h2N = pNB; h2A = pAB; h2D = pDB;
        pNB = bNLE; pAB = bA; pDB = bD;
    end

    // Issue one request to dutA, scramble DATA while busy, and return the START-to-DONE latency.
    task automatic runA(input logic [7:0] dat, input logic start, input logic clr, output int lat);
        @(negedge clk);
        aData = dat; aStart = start; aClr = clr;
        @(posedge clk);
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            aStart = 1'b0; aClr = 1'b0; aData = ~dat;
            if (aDone === 1'b1) begin
                lat = n;
                break;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({aA, aD, aNLE, aNMR, aBusy, aDone} !== 8'b000_0_1_0_0_0) begin
            errors++;
            $display("FAIL reset_ctl got A=%0d D=%b nLE=%b nMR=%b BUSY=%b DONE=%b want 0 0 1 0 0 0",
                     aA, aD, aNLE, aNMR, aBusy, aDone);
        end
        checks++;
        if (aShadow !== 8'h00) begin
            errors++;
            $display("FAIL reset_shadow got %h want 00", aShadow);
        end
        nRST = 1'b1;
        @(negedge clk);
        checks++;
        if (aNMR !== 1'b1 || bNMR !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_nmr got %b/%b want 1/1", aNMR, bNMR);
        end
    endtask

    task automatic test_write_a5();
        int lat;
        int pBase, vBase;
        logic [7:0] exp;
        exp = 8'hA5;
        pBase = pulsesA; vBase = violA;
        runA(8'hA5, 1'b1, 1'b0, lat);
        checks++;
        if (lat != LAT_A5) begin
            errors++;
            $display("FAIL write_latency got %0d want %0d", lat, LAT_A5);
        end
        checks++;
        if (aShadow !== 8'hA5 || latchA !== 8'hA5) begin
            errors++;
            $display("FAIL write_result got shadow=%h latch=%h want a5/a5", aShadow, latchA);
        end
        checks++;
        if (aBusy !== 1'b0) begin
            errors++;
            $display("FAIL write_busy_in_fin got %b want 0", aBusy);
        end
        checks++;
        if (pulsesA - pBase != PULSES_A5 || violA != vBase) begin
            errors++;
            $display("FAIL write_pulses got pulses=%0d viol=%0d want %0d/0",
                     pulsesA - pBase, violA - vBase, PULSES_A5);
        end
`ifndef HC259_WRITER_SKIP_EN
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (logA[(pBase + i) % 64] !== {3'(i), exp[i]}) begin
                errors++;
                $display("FAIL write_bit%0d got A/D=%b want %b", i, logA[(pBase + i) % 64], {3'(i), exp[i]});
            end
        end
`endif
        @(negedge clk);
        checks++;
        if (aDone !== 1'b0 || aNLE !== 1'b1) begin
            errors++;
            $display("FAIL done_one_cycle got DONE=%b nLE=%b want 0/1", aDone, aNLE);
        end
    endtask

    task automatic test_clear_wins();
        int lat;
        int pBase, mBase, vBase;
        pBase = pulsesA; mBase = nmrLowA; vBase = violA;
        runA(8'h77, 1'b1, 1'b1, lat);
        checks++;
        if (lat != 2) begin
            errors++;
            $display("FAIL clear_latency got %0d want 2", lat);
        end
        checks++;
        if (nmrLowA - mBase != 1 || pulsesA != pBase || violA != vBase) begin
            errors++;
            $display("FAIL clear_strobes got nMRlow=%0d pulses=%0d viol=%0d want 1/0/0",
                     nmrLowA - mBase, pulsesA - pBase, violA - vBase);
        end
        checks++;
        if (aShadow !== 8'h00 || latchA !== 8'h00) begin
            errors++;
            $display("FAIL clear_result got shadow=%h latch=%h want 00/00", aShadow, latchA);
        end
    endtask

`ifdef HC259_WRITER_SKIP_EN
    task automatic test_skip();
        int lat;
        int pBase;
        runA(8'hA5, 1'b1, 1'b0, lat);
        checks++;
        if (lat != 17 || aShadow !== 8'hA5) begin
            errors++;
            $display("FAIL skip_prep got lat=%0d shadow=%h want 17/a5", lat, aShadow);
        end
        pBase = pulsesA;
        runA(8'hA4, 1'b1, 1'b0, lat);
        checks++;
        if (lat != 11 || pulsesA - pBase != 1 || logA[pBase % 64] !== 4'b000_0) begin
            errors++;
            $display("FAIL skip_one_bit got lat=%0d pulses=%0d A/D=%b want 11/1/0000",
                     lat, pulsesA - pBase, logA[pBase % 64]);
        end
        checks++;
        if (aShadow !== 8'hA4 || latchA !== 8'hA4) begin
            errors++;
            $display("FAIL skip_one_result got shadow=%h latch=%h want a4/a4", aShadow, latchA);
        end
        pBase = pulsesA;
        runA(8'hA4, 1'b1, 1'b0, lat);
        checks++;
        if (lat != 9 || pulsesA != pBase) begin
            errors++;
            $display("FAIL skip_all got lat=%0d pulses=%0d want 9/0", lat, pulsesA - pBase);
        end
    endtask
`endif

    task automatic test_params();
        int lat;
        int pBase, vBase;
        pBase = pulsesB; vBase = violB;
        @(negedge clk);
        bData = 8'hFF; bStart = 1'b1; bClr = 1'b0;
        @(posedge clk);
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            bStart = 1'b0; bClr = 1'b0;
            if (n == 5) begin
                bStart = 1'b1; bClr = 1'b1; bData = 8'h00;
            end
            if (bDone === 1'b1) begin
                lat = n;
                break;
            end
        end
        bStart = 1'b0; bClr = 1'b0;
        #1;
        checks++;
        if (lat != 49) begin
            errors++;
            $display("FAIL param_latency got %0d want 49", lat);
        end
        checks++;
        if (pulsesB - pBase != 8 || violB != vBase) begin
            errors++;
            $display("FAIL param_timing got pulses=%0d viol=%0d want 8/0", pulsesB - pBase, violB - vBase);
        end
        checks++;
        if (bShadow !== 8'hFF || latchB !== 8'hFF) begin
            errors++;
            $display("FAIL param_result got shadow=%h latch=%h want ff/ff", bShadow, latchB);
        end
    endtask

    task automatic test_reset_mid();
        int dBase;
        bit found;
        found = 1'b0;
        @(negedge clk);
        aData = 8'hFF; aStart = 1'b1; aClr = 1'b0;
        @(posedge clk);
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            aStart = 1'b0;
            if (aNLE === 1'b0 && aA === 3'd3) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL abort_reach_bit3 got not_found want strobe_of_bit3");
        end
        nRST = 1'b0;
        dBase = doneA;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (aNLE !== 1'b1 || aNMR !== 1'b0 || aBusy !== 1'b0 || aDone !== 1'b0 || aShadow !== 8'h00) begin
            errors++;
            $display("FAIL abort_state got nLE=%b nMR=%b BUSY=%b DONE=%b shadow=%h want 1 0 0 0 00",
                     aNLE, aNMR, aBusy, aDone, aShadow);
        end
        nRST = 1'b1;
        repeat (40) @(negedge clk);
        checks++;
        if (doneA != dBase || aNMR !== 1'b1 || aBusy !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done got dones=%0d nMR=%b BUSY=%b want 0/1/0", doneA - dBase, aNMR, aBusy);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        nRST = 1'b0;
        aStart = 1'b0; aClr = 1'b0; aData = 8'h00;
        bStart = 1'b0; bClr = 1'b0; bData = 8'h00;
        test_reset();
        test_write_a5();
        test_clear_wins();
`ifdef HC259_WRITER_SKIP_EN
        test_skip();
`endif
        test_params();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
